barrier_damage_tracker: RTL and testbench

BARRIER_DAMAGE_TRACKER -- requirements
Module: barrier_damage_tracker

---
 rtl/barrier_damage_tracker.sv | 146 ++++++++++++++
 tb/tb_barrier_damage_tracker.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/barrier_damage_tracker.sv
//------------------------------------------------------------------------------
// Module  : barrier_damage_tracker
// Brief   : Per-block barrier health store with hit/decrement FSM and restore
//           sweep. Optional BARRIER_DESTROY_CNT_EN adds a destroyed-block count.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module barrier_damage_tracker #(
  parameter int NUM_BARR   = 4,
  parameter int MAX_HEALTH = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hit_valid,
  input  logic [1:0] hit_barrier,
  input  logic [1:0] hit_x,
  input  logic [1:0] hit_y,
  output logic       hit_ready,
  output logic       hit_done,
  output logic       hit_absorbed,
  input  logic       restore_req,
  output logic       busy,
  input  logic [1:0] rd_barrier,
  input  logic [1:0] rd_x,
  input  logic [1:0] rd_y,
  output logic [1:0] rd_health
`ifdef BARRIER_DESTROY_CNT_EN
  ,
  output logic [6:0] destroyed_cnt
`endif
);

  localparam int         DEPTH    = NUM_BARR * 16;
  localparam logic [2:0] NB       = 3'(NUM_BARR);
  localparam logic [1:0] MAX_H    = 2'(MAX_HEALTH);
  localparam logic [5:0] LAST_IDX = 6'(DEPTH - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_APPLY   = 2'd1;
  localparam logic [1:0] S_RESTORE = 2'd2;

  logic [1:0] state_q, state_d;
  logic [5:0] hit_idx_q, hit_idx_d;
  logic       hit_ok_q, hit_ok_d;
  logic [5:0] sweep_idx_q, sweep_idx_d;
  logic [1:0] health_q [DEPTH];
  logic [1:0] rd_health_q;
  logic [1:0] cur_health;
  logic       rd_ok;

  assign hit_ready = (state_q == S_IDLE) && !restore_req;
  assign busy      = (state_q == S_RESTORE);
  assign rd_health = rd_health_q;
  assign rd_ok     = ({1'b0, rd_barrier} < NB);

  assign cur_health = hit_ok_q ? health_q[hit_idx_q] : 2'd0;
  // Gated by rst so an aborted hit never shows a completion pulse.
  assign hit_done     = (state_q == S_APPLY) && !rst;
  assign hit_absorbed = hit_done && (cur_health != 2'd0);

  always_comb begin
    state_d     = state_q;
    hit_idx_d   = hit_idx_q;
    hit_ok_d    = hit_ok_q;
    sweep_idx_d = sweep_idx_q;
    case (state_q)
      S_IDLE: begin
        if (restore_req) begin
          state_d     = S_RESTORE;
          sweep_idx_d = 6'd0;
        end else if (hit_valid) begin
          hit_idx_d = {hit_barrier, hit_y, hit_x};
          hit_ok_d  = ({1'b0, hit_barrier} < NB);
          state_d   = S_APPLY;
        end
      end
      S_APPLY: state_d = S_IDLE;
      S_RESTORE: begin
        if (sweep_idx_q == LAST_IDX) begin
          state_d     = S_IDLE;
          sweep_idx_d = 6'd0;
        end else begin
          sweep_idx_d = sweep_idx_q + 6'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      hit_idx_q   <= 6'd0;
      hit_ok_q    <= 1'b0;
      sweep_idx_q <= 6'd0;
    end else begin
      state_q     <= state_d;
      hit_idx_q   <= hit_idx_d;
      hit_ok_q    <= hit_ok_d;
      sweep_idx_q <= sweep_idx_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        health_q[i] <= MAX_H;
      end
    end else if (hit_absorbed) begin
      health_q[hit_idx_q] <= cur_health - 2'd1;
    end else if (state_q == S_RESTORE) begin
      health_q[sweep_idx_q] <= MAX_H;
    end
  end

  // Nonblocking read returns the pre-write value on a same-cycle update.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_health_q <= 2'd0;
    end else if (rd_ok) begin
      rd_health_q <= health_q[{rd_barrier, rd_y, rd_x}];
    end else begin
      rd_health_q <= 2'd0;
    end
  end

`ifdef BARRIER_DESTROY_CNT_EN
  logic [6:0] destroyed_q;

  assign destroyed_cnt = destroyed_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      destroyed_q <= 7'd0;
    end else if ((state_q == S_IDLE) && restore_req) begin
      destroyed_q <= 7'd0;
    end else if (hit_absorbed && (cur_health == 2'd1)) begin
      destroyed_q <= destroyed_q + 7'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_barrier_damage_tracker.sv
//------------------------------------------------------------------------------
// Module  : tb_barrier_damage_tracker
// Brief   : Directed self-checking bench for barrier_damage_tracker.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_barrier_damage_tracker;

  logic       clk = 1'b0;
  logic       rst;
  logic       hit_valid;
  logic [1:0] hit_barrier, hit_x, hit_y;
  logic       hit_ready, hit_done, hit_absorbed;
  logic       restore_req;
  logic       busy;
  logic [1:0] rd_barrier, rd_x, rd_y;
  logic [1:0] rd_health;
`ifdef BARRIER_DESTROY_CNT_EN
  logic [6:0] destroyed_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  barrier_damage_tracker #(.NUM_BARR(4), .MAX_HEALTH(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .hit_valid    (hit_valid),
    .hit_barrier  (hit_barrier),
    .hit_x        (hit_x),
    .hit_y        (hit_y),
    .hit_ready    (hit_ready),
    .hit_done     (hit_done),
    .hit_absorbed (hit_absorbed),
    .restore_req  (restore_req),
    .busy         (busy),
    .rd_barrier   (rd_barrier),
    .rd_x         (rd_x),
    .rd_y         (rd_y),
    .rd_health    (rd_health)
`ifdef BARRIER_DESTROY_CNT_EN
    ,
    .destroyed_cnt(destroyed_cnt)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_hit(input logic v, input logic [1:0] b, input logic [1:0] x, input logic [1:0] y);
    hit_valid   = v;
    hit_barrier = b;
    hit_x       = x;
    hit_y       = y;
  endtask

  task automatic set_rd(input logic [1:0] b, input logic [1:0] x, input logic [1:0] y);
    rd_barrier = b;
    rd_x       = x;
    rd_y       = y;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    restore_req = 1'b0;
    set_hit(1'b0, 2'd0, 2'd0, 2'd0);
    set_rd(2'd2, 2'd1, 2'd3);
    tick();
    tick();
    rst = 1'b0;
    #1;
    total++; if (hit_done !== 1'b0) begin bad++; $display("FAIL reset_hit_done got=%b exp=0", hit_done); end
    total++; if (hit_absorbed !== 1'b0) begin bad++; $display("FAIL reset_absorbed got=%b exp=0", hit_absorbed); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (rd_health !== 2'd0) begin bad++; $display("FAIL reset_rd_health got=%0d exp=0", rd_health); end
    total++; if (hit_ready !== 1'b1) begin bad++; $display("FAIL reset_hit_ready got=%b exp=1", hit_ready); end
    tick();
    total++; if (rd_health !== 2'd3) begin bad++; $display("FAIL reset_read_b2x1y3 got=%0d exp=3", rd_health); end
  endtask

  task automatic test_hits();
    logic [3:0] exp_abs;
    exp_abs = 4'b0111;
    for (int i = 0; i < 4; i++) begin
      set_hit(1'b1, 2'd0, 2'd0, 2'd0);
      #1;
      total++; if (hit_ready !== 1'b1) begin bad++; $display("FAIL hits_ready[%0d] got=%b exp=1", i, hit_ready); end
      tick();
      set_hit(1'b0, 2'd0, 2'd0, 2'd0);
      total++; if (hit_done !== 1'b1) begin bad++; $display("FAIL hits_done[%0d] got=%b exp=1", i, hit_done); end
      total++; if (hit_absorbed !== exp_abs[i]) begin bad++; $display("FAIL hits_absorbed[%0d] got=%b exp=%b", i, hit_absorbed, exp_abs[i]); end
      tick();
      total++; if (hit_done !== 1'b0 || hit_absorbed !== 1'b0) begin bad++; $display("FAIL hits_idle[%0d] got=%b%b exp=00", i, hit_done, hit_absorbed); end
    end
    set_rd(2'd0, 2'd0, 2'd0);
    tick();
    total++; if (rd_health !== 2'd0) begin bad++; $display("FAIL hits_final_health got=%0d exp=0", rd_health); end
`ifdef BARRIER_DESTROY_CNT_EN
    total++; if (destroyed_cnt !== 7'd1) begin bad++; $display("FAIL hits_destroyed got=%0d exp=1", destroyed_cnt); end
`endif
  endtask

  task automatic test_back_to_back();
    int accepts;
    accepts = 0;
    set_hit(1'b1, 2'd3, 2'd3, 2'd3);
    for (int i = 0; i < 6; i++) begin
      #1;
      total++; if (hit_ready !== (i % 2 == 0)) begin bad++; $display("FAIL b2b_ready[%0d] got=%b exp=%b", i, hit_ready, (i % 2 == 0)); end
      total++; if (hit_absorbed !== (i % 2 == 1)) begin bad++; $display("FAIL b2b_absorbed[%0d] got=%b exp=%b", i, hit_absorbed, (i % 2 == 1)); end
      if (hit_ready && hit_valid) accepts++;
      tick();
    end
    set_hit(1'b0, 2'd0, 2'd0, 2'd0);
    total++; if (accepts != 3) begin bad++; $display("FAIL b2b_accepts got=%0d exp=3", accepts); end
    set_rd(2'd3, 2'd3, 2'd3);
    tick();
    total++; if (rd_health !== 2'd0) begin bad++; $display("FAIL b2b_health got=%0d exp=0", rd_health); end
`ifdef BARRIER_DESTROY_CNT_EN
    total++; if (destroyed_cnt !== 7'd2) begin bad++; $display("FAIL b2b_destroyed got=%0d exp=2", destroyed_cnt); end
`endif
  endtask

  task automatic test_restore();
    int cycles;
    cycles = 0;
    restore_req = 1'b1;
    set_hit(1'b1, 2'd0, 2'd0, 2'd0);
    set_rd(2'd3, 2'd3, 2'd3);
    #1;
    total++; if (hit_ready !== 1'b0) begin bad++; $display("FAIL restore_ready_same got=%b exp=0", hit_ready); end
    tick();
    restore_req = 1'b0;
    while (busy === 1'b1 && cycles < 100) begin
      if (hit_ready !== 1'b0 || hit_done !== 1'b0) begin
        total++; bad++;
        $display("FAIL restore_holdoff cycle=%0d ready=%b done=%b exp=00", cycles, hit_ready, hit_done);
      end
      cycles++;
      tick();
    end
    total++; if (cycles != 64) begin bad++; $display("FAIL restore_busy_cycles got=%0d exp=64", cycles); end
`ifdef BARRIER_DESTROY_CNT_EN
    total++; if (destroyed_cnt !== 7'd0) begin bad++; $display("FAIL restore_destroyed got=%0d exp=0", destroyed_cnt); end
`endif
    #1;
    total++; if (hit_ready !== 1'b1) begin bad++; $display("FAIL restore_first_idle_ready got=%b exp=1", hit_ready); end
    tick();
    set_hit(1'b0, 2'd0, 2'd0, 2'd0);
    total++; if (hit_done !== 1'b1 || hit_absorbed !== 1'b1) begin bad++; $display("FAIL restore_hit got=%b%b exp=11", hit_done, hit_absorbed); end
    total++; if (rd_health !== 2'd3) begin bad++; $display("FAIL restore_b3_block15 got=%0d exp=3", rd_health); end
    set_rd(2'd0, 2'd0, 2'd0);
    tick();
    total++; if (rd_health !== 2'd3) begin bad++; $display("FAIL restore_b0_old got=%0d exp=3", rd_health); end
    tick();
    total++; if (rd_health !== 2'd2) begin bad++; $display("FAIL restore_b0_new got=%0d exp=2", rd_health); end
  endtask

  task automatic test_same_cycle_read();
    set_hit(1'b1, 2'd1, 2'd2, 2'd2);
    set_rd(2'd1, 2'd2, 2'd2);
    tick();
    set_hit(1'b0, 2'd0, 2'd0, 2'd0);
    tick();
    total++; if (rd_health !== 2'd3) begin bad++; $display("FAIL samecycle_old got=%0d exp=3", rd_health); end
    tick();
    total++; if (rd_health !== 2'd2) begin bad++; $display("FAIL samecycle_new got=%0d exp=2", rd_health); end
  endtask

  task automatic test_reset_mid_restore();
    restore_req = 1'b1;
    tick();
    restore_req = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrestore_busy got=%b exp=0", busy); end
    total++; if (hit_ready !== 1'b1) begin bad++; $display("FAIL midrestore_ready got=%b exp=1", hit_ready); end
    set_rd(2'd1, 2'd2, 2'd2);
    tick();
    total++; if (rd_health !== 2'd3) begin bad++; $display("FAIL midrestore_b1x2y2 got=%0d exp=3", rd_health); end
    set_rd(2'd0, 2'd0, 2'd0);
    tick();
    total++; if (rd_health !== 2'd3) begin bad++; $display("FAIL midrestore_b0x0y0 got=%0d exp=3", rd_health); end
  endtask

  task automatic test_reset_mid_apply();
    set_hit(1'b1, 2'd2, 2'd0, 2'd0);
    tick();
    set_hit(1'b0, 2'd0, 2'd0, 2'd0);
    rst = 1'b1;
    #1;
    total++; if (hit_done !== 1'b0) begin bad++; $display("FAIL midapply_done got=%b exp=0", hit_done); end
    tick();
    rst = 1'b0;
    #1;
    total++; if (hit_done !== 1'b0) begin bad++; $display("FAIL midapply_done_after got=%b exp=0", hit_done); end
    set_rd(2'd2, 2'd0, 2'd0);
    tick();
    total++; if (rd_health !== 2'd3) begin bad++; $display("FAIL midapply_health got=%0d exp=3", rd_health); end
  endtask

  initial begin
    test_reset();
    test_hits();
    test_back_to_back();
    test_restore();
    test_same_cycle_read();
    test_reset_mid_restore();
    test_reset_mid_apply();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
